// File: rtl/lfsr_param_pkg.sv
// Shared definitions for the parameterised LFSR: maximal-length tap table,
// counter sizing and the next-state source encoding.
package lfsr_param_pkg;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 32;
    // Freshness counter must hold WIDTH + STEPS (up to 64) before saturation
    localparam int CNT_W     = 7;

    typedef enum logic [1:0] {
        NS_HOLD    = 2'd0,
        NS_STEP    = 2'd1,
        NS_RECOVER = 2'd2,
        NS_LOAD    = 2'd3
    } ns_sel_e;

    // Bit i set means state[i] feeds the XOR; every entry is maximal length
    function automatic logic [31:0] max_taps(input int width);
        case (width)
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_param_if.sv
// Control, seed and word handshake bundle between an LFSR and its user.
interface lfsr_param_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] state;
    logic             next_bit;
    logic             word_valid;
    logic             word_ready;
    logic             wrap;
    logic             lockup;

    modport master (
        output en, load, seed, word_ready,
        input  state, next_bit, word_valid, wrap, lockup
    );

    modport slave (
        input  en, load, seed, word_ready,
        output state, next_bit, word_valid, wrap, lockup
    );
endinterface

// File: rtl/lfsr_step.sv
// One combinational Fibonacci left-shift step plus a compare of the
// resulting state against the stored seed.
module lfsr_step
    import lfsr_param_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(max_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] ref_seed,
    output logic [WIDTH-1:0] nxt,
    output logic             match
);
    logic fb_s;

    assign fb_s  = ^(cur & TAPS);
    assign nxt   = {cur[WIDTH-2:0], fb_s};
    assign match = (nxt == ref_seed);
endmodule

// File: rtl/lfsr_param.sv
// Parameterised Fibonacci LFSR advancing STEPS shifts per enabled clock,
// with seed load, all-zero recovery, wrap detection and a lossy word handshake.
module lfsr_param
    import lfsr_param_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(max_taps(WIDTH)),
    parameter int               STEPS = 1
) (
    input logic         clk,
    input logic         rst,
    lfsr_param_if.slave bus
);
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH || TAPS == {WIDTH{1'b0}} ||
        STEPS < 1 || STEPS > WIDTH) begin : g_param_err
        $fatal(1, "lfsr_param: illegal WIDTH, TAPS or STEPS");
    end

    localparam logic [WIDTH-1:0] STATE_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LIM   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_STEP  = CNT_W'(STEPS);

    logic [WIDTH-1:0]          state_r;
    logic [WIDTH-1:0]          seed_r;
    logic [CNT_W-1:0]          cnt_r;
    logic                      word_valid_r;
    logic                      wrap_r;
    logic                      lockup_r;

    logic [WIDTH-1:0]          seed_fix_s;
    logic [STEPS:0][WIDTH-1:0] stage_s;
    logic [STEPS-1:0]          hit_s;
    ns_sel_e                   ns_sel_s;
    logic [WIDTH-1:0]          state_nxt_s;
    logic [CNT_W-1:0]          cnt_base_s;
    logic [CNT_W-1:0]          cnt_sum_s;
    logic [CNT_W-1:0]          cnt_nxt_s;

    // A zero seed would lock the register, so it is promoted to 1
    assign seed_fix_s = (bus.seed == {WIDTH{1'b0}}) ? STATE_ONE : bus.seed;

    assign stage_s[0] = state_r;

    for (genvar i = 0; i < STEPS; i++) begin : g_chain
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_step (
            .cur      (stage_s[i]),
            .ref_seed (seed_r),
            .nxt      (stage_s[i+1]),
            .match    (hit_s[i])
        );
    end

    // Select the next-state source: load > recovery > step > hold
    always_comb begin
        ns_sel_s = NS_HOLD;
        if (bus.load) begin
            ns_sel_s = NS_LOAD;
        end else if (bus.en) begin
            if (state_r == {WIDTH{1'b0}}) begin
                ns_sel_s = NS_RECOVER;
            end else begin
                ns_sel_s = NS_STEP;
            end
        end else begin
            ns_sel_s = NS_HOLD;
        end
    end

    // Next state and freshness count; recovery does not count as fresh output
    always_comb begin
        state_nxt_s = state_r;
        cnt_base_s  = (word_valid_r && bus.word_ready) ? {CNT_W{1'b0}} : cnt_r;
        cnt_sum_s   = cnt_base_s + CNT_STEP;
        cnt_nxt_s   = cnt_base_s;
        case (ns_sel_s)
            NS_LOAD: begin
                state_nxt_s = seed_fix_s;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
            NS_RECOVER: begin
                state_nxt_s = STATE_ONE;
                cnt_nxt_s   = cnt_base_s;
            end
            NS_STEP: begin
                state_nxt_s = stage_s[STEPS];
                cnt_nxt_s   = (cnt_sum_s >= CNT_LIM) ? CNT_LIM : cnt_sum_s;
            end
            NS_HOLD: begin
                state_nxt_s = state_r;
                cnt_nxt_s   = cnt_base_s;
            end
            default: begin
                state_nxt_s = state_r;
                cnt_nxt_s   = cnt_base_s;
            end
        endcase
    end

    // State, stored seed, counter and registered status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= seed_fix_s;
            seed_r       <= seed_fix_s;
            cnt_r        <= {CNT_W{1'b0}};
            word_valid_r <= 1'b0;
            wrap_r       <= 1'b0;
            lockup_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            if (ns_sel_s == NS_LOAD) begin
                seed_r   <= seed_fix_s;
            end
            cnt_r        <= cnt_nxt_s;
            word_valid_r <= (cnt_nxt_s == CNT_LIM);
            wrap_r       <= (ns_sel_s == NS_STEP) && (|hit_s);
            lockup_r     <= (ns_sel_s == NS_RECOVER);
        end
    end

    // The bit shifted in by the first stage is the single-step feedback
    assign bus.next_bit   = stage_s[1][0];
    assign bus.state      = state_r;
    assign bus.word_valid = word_valid_r;
    assign bus.wrap       = wrap_r;
    assign bus.lockup     = lockup_r;
endmodule

// File: doc/lfsr_param.md
LFSR_PARAM -- requirements
Module: lfsr_param

Interface
REQ-001 Parameter: WIDTH, 4, register width in bits, legal range 4..32.
REQ-002 Parameter: TAPS, maximal-length mask for WIDTH from the shared package, feedback tap mask where bit i set means state[i] feeds the XOR.
REQ-003 Parameter: STEPS, 1, LFSR shifts per enabled clock, legal range 1..WIDTH.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 en  in  1  advance enable.
REQ-008 load  in  1  synchronous seed load strobe.
REQ-009 seed  in  WIDTH  seed value, used at reset and on load.
REQ-010 state  out  WIDTH  current register contents.
REQ-011 next_bit  out  1  single-step feedback bit of current state, combinational.
REQ-012 word_valid  out  1  a fresh word is available on state.
REQ-013 word_ready  in  1  consumer accepts the word.
REQ-014 wrap  out  1  one-cycle pulse when the sequence returns to the stored seed.
REQ-015 lockup  out  1  one-cycle pulse when all-zero recovery fires.

Function
REQ-016 Single step SHALL be Fibonacci, left-shift: state <= {state[WIDTH-2:0], ^(state & TAPS)}.
REQ-017 With en=1, one clock SHALL apply STEPS single steps; with en=0, state SHALL hold.
REQ-018 Next-state priority SHALL be load > lockup recovery > step > hold.
REQ-019 On load, state and the internal stored seed SHALL take seed; a zero seed SHALL be replaced by 1.
REQ-020 If state is all-zero and en=1 with no load, the next state SHALL be 1 and lockup SHALL pulse for that cycle.
REQ-021 A freshness counter SHALL add STEPS per enabled advance and saturate at WIDTH.
REQ-022 word_valid SHALL be 1 exactly when the freshness counter equals WIDTH.
REQ-023 On a cycle with word_valid && word_ready, the counter SHALL clear, or become STEPS if the same cycle also advances.
REQ-024 While word_valid=1 and word_ready=0, state SHALL continue to advance; words are lossy, not stalled.
REQ-025 wrap SHALL pulse, registered, on the cycle after an advance whose resulting state equals the stored seed, including the case where the match occurs at any intermediate step of a multi-step clock.
REQ-026 load SHALL clear the freshness counter and SHALL suppress wrap and lockup that cycle.
REQ-027 TAPS=0 or STEPS out of range SHALL be rejected at elaboration.

Reset
REQ-028 While rst=0: state and stored seed SHALL take seed (zero replaced by 1); counter=0; word_valid=0; wrap=0; lockup=0.
REQ-029 Reset asserted mid-operation SHALL take effect immediately, without waiting for clk.

Structure
REQ-030 A shared package SHALL hold the per-width maximal tap table (4..32) and the lookup function that supplies the TAPS default.
REQ-031 One sub-module, lfsr_step, SHALL implement the combinational single-step function, chained STEPS times with a per-stage seed compare.

Verification
REQ-032 WIDTH=4, TAPS=4'b1100, STEPS=1, seed=0001, en=1: state SHALL follow 0010, 0100, 1001, 0011, and wrap SHALL pulse once after the 15th step.
REQ-033 Same configuration, STEPS=4: word_valid SHALL rise after the first enabled clock; with word_ready held 1 it SHALL stay 1; the state after the first clock SHALL be 0011.
REQ-034 WIDTH=8, load with seed=0x00: state SHALL become 0x01 and lockup SHALL not pulse; forcing state to 0 via a zero-recovery path SHALL yield state=0x01 and one lockup pulse.
REQ-035 WIDTH=16, STEPS=1, word_ready=0: word_valid SHALL rise after 16 enabled clocks, and state SHALL keep changing while valid; one ready cycle SHALL drop valid for 15 clocks.
REQ-036 Assert rst between clock edges mid-sequence: state SHALL show seed asynchronously, and outputs SHALL be 0 per REQ-028.
REQ-037 load and en together on a clock with seed=0x5: state SHALL be 0x5, with no step, wrap, or lockup that cycle.
